ahb_lite_single_master: RTL
===========================

Name: ahb_lite_single_master

Overview:
- AHB-Lite initiator that issues single, non-burst transfers on behalf of fabric logic: register pokes to AHB peripherals, and bench stimulus for our AHB register slaves.
- Accepts one command at a time over a valid/ready handshake and runs the address phase and the data phase.
- Returns read data and status as a one-cycle response pulse.
- Sits between control FSMs (game control, image select) and the AHB slave register files on the same AHB_HCLK domain.

Parameters:
- TIMEOUT_CYCLES, 256: maximum consecutive AHB_HREADY-low cycles in the data phase before the transfer is abandoned. 0 disables the timeout.
- HPROT_VAL, 4'b0011: constant driven on AHB_HPROT (non-cacheable, non-bufferable, privileged data access).

Ports:
- AHB_HCLK  in  1  bus clock; all logic rising-edge.
- AHB_HRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  32  byte address.
- cmd_size  in  3  HSIZE encoding; only 0 (byte), 1 (half) and 2 (word) are legal.
- cmd_wdata  in  32  write data, right-justified in LSBs.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data, zero-extended, LSB-justified; 0 for writes and errors.
- rsp_error  out  1  slave ERROR, illegal command, or timeout.
- rsp_timeout  out  1  error was a timeout.
- AHB_HADDR  out  32  address.
- AHB_HTRANS  out  2  IDLE=00, NONSEQ=10 only.
- AHB_HWRITE  out  1  write/read.
- AHB_HSIZE  out  3  transfer size.
- AHB_HBURST  out  3  constant 000 (SINGLE).
- AHB_HPROT  out  4  HPROT_VAL.
- AHB_HMASTLOCK  out  1  constant 0.
- AHB_HWDATA  out  32  write data, lane-placed.
- AHB_HRDATA  in  32  read data.
- AHB_HREADY  in  1  transfer-complete/ready.
- AHB_HRESP  in  2  00=OKAY, 01=ERROR.

Behaviour:
- Reset values of all outputs:
  - cmd_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0.
  - AHB_HTRANS=00, AHB_HADDR=0, AHB_HWRITE=0, AHB_HSIZE=0, AHB_HWDATA=0.
  - FSM in IDLE.
- Reset asserted mid-transfer returns to IDLE immediately. No response pulse is generated for the aborted command.
- FSM IDLE:
  - cmd_ready=1.
  - On accept, latch all cmd_* fields.
  - If the command is illegal (cmd_size>2, or address misaligned: half with addr[0]!=0, word with addr[1:0]!=0), go to RESP with rsp_error=1. No bus activity.
  - Otherwise go to ADDR.
- FSM ADDR:
  - Drive HTRANS=NONSEQ, HADDR, HWRITE and HSIZE from the latched command.
  - Leave for DATA on the first edge with HREADY=1. Hold all address signals stable while HREADY=0.
- FSM DATA:
  - HTRANS=IDLE.
  - Drive HWDATA, lane-replicated: byte copied to all 4 lanes, half copied to both halves, word unchanged. Hold it stable until completion.
  - Wait-state counter counts HREADY=0 cycles.
  - On HREADY=1 with HRESP=00: capture HRDATA lane-extracted (byte lane addr[1:0], half lane addr[1]), then go to RESP.
  - On HRESP=01: go to RESP with rsp_error=1 on whichever edge HREADY=1 completes the two-cycle ERROR response. HTRANS is already IDLE, so no cancel is needed.
  - If the counter reaches TIMEOUT_CYCLES: go to RESP with rsp_error=1 and rsp_timeout=1.
- FSM RESP:
  - rsp_valid=1 for exactly one cycle; rsp_* hold until the next response.
  - Return to IDLE. cmd_ready rises the cycle after rsp_valid.
- Zero-wait latency: accept at edge N, ADDR in cycle N..N+1, DATA N+1..N+2, rsp_valid in cycle N+2..N+3. Each wait state adds one cycle.
- cmd_ready is low from the accept edge until return to IDLE. cmd_valid while busy is ignored.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE, HTRANS_NONSEQ.
  - HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD.
  - HRESP_OKAY, HRESP_ERROR.
  - HBURST_SINGLE.
  - State encoding IDLE/ADDR/DATA/RESP.
- One sub-module, ahb_lane_align (combinational): write-lane replication and read-lane extraction/zero-extension from size and addr[1:0]. It is reused by slave-side blocks.

Test Plan:
1. Word write addr 0x0000_0004, data 0x0000_00A5, HREADY tied 1 -> HTRANS=10 one cycle, then HWDATA=0x0000_00A5. rsp_valid 3 cycles after accept, rsp_error=0.
2. Word read 0x0000_000C, slave returns 0x1234_5678 after 3 wait states -> HADDR/HTRANS held during the address phase only. rsp_rdata=0x1234_5678 at accept+6.
3. Byte read addr 0x0000_0003, HRDATA=0xAABB_CCDD -> rsp_rdata=0x0000_00AA. Byte write 0x5C -> HWDATA=0x5C5C_5C5C.
4. Half write addr 0x0000_0001 -> no HTRANS activity; rsp_valid the cycle after accept with rsp_error=1, rsp_timeout=0.
5. Slave drives HRESP=01 with HREADY 0 then 1 -> rsp_error=1, rsp_rdata=0. Next command is accepted normally.
6. HREADY stuck 0 with TIMEOUT_CYCLES=8 -> rsp_error=1, rsp_timeout=1 after 8 wait cycles. AHB_HRESETn pulsed mid-DATA on a separate run -> HTRANS=00, cmd_ready=1, no rsp_valid.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, master FSM states and the command legality check.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } ahb_state_t;

  // Only byte/half/word sizes are supported, and the address must be naturally aligned.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: cmd_legal = 1'b1;
      HSIZE_HALF: cmd_legal = ~addr_lo[0];
      HSIZE_WORD: cmd_legal = (addr_lo == 2'b00);
      default:    cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane placement for AHB data: write replication and read extraction with zero-extension.
module ahb_lane_align
  import ahb_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_lanes,
  input  logic [31:0] rdata_bus,
  output logic [31:0] rdata_ext
);

  always_comb begin
    wdata_lanes = wdata;
    rdata_ext   = rdata_bus;
    case (size)
      HSIZE_BYTE: begin
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {24'h000000, rdata_bus[{addr_lo, 3'b000} +: 8]};
      end
      HSIZE_HALF: begin
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = addr_lo[1] ? {16'h0000, rdata_bus[31:16]}
                                 : {16'h0000, rdata_bus[15:0]};
      end
      default: begin
        wdata_lanes = wdata;
        rdata_ext   = rdata_bus;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_single_master.sv
// AHB-Lite initiator issuing one single (non-burst) transfer per accepted command.
module ahb_lite_single_master
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
  input  logic        AHB_HCLK,
  input  logic        AHB_HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic [31:0] AHB_HADDR,
  output logic [1:0]  AHB_HTRANS,
  output logic        AHB_HWRITE,
  output logic [2:0]  AHB_HSIZE,
  output logic [2:0]  AHB_HBURST,
  output logic [3:0]  AHB_HPROT,
  output logic        AHB_HMASTLOCK,
  output logic [31:0] AHB_HWDATA,
  input  logic [31:0] AHB_HRDATA,
  input  logic        AHB_HREADY,
  input  logic [1:0]  AHB_HRESP
);

  localparam int unsigned WCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  ahb_state_t        state, state_nxt;
  logic              lat_write;
  logic [31:0]       lat_addr;
  logic [2:0]        lat_size;
  logic [31:0]       lat_wdata;
  logic [WCNT_W-1:0] wait_cnt, wait_nxt;
  logic              accept, cmd_ok, timeout_hit;
  logic              data_done, data_err, data_tmo;
  logic [31:0]       rdata_ext;

  assign accept      = (state == ST_IDLE) && cmd_valid;
  assign cmd_ok      = cmd_legal(cmd_size, cmd_addr[1:0]);
  assign wait_nxt    = wait_cnt + WCNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_nxt == WCNT_W'(TIMEOUT_CYCLES));

  ahb_lane_align u_lane_align (
    .size        (lat_size),
    .addr_lo     (lat_addr[1:0]),
    .wdata       (lat_wdata),
    .wdata_lanes (AHB_HWDATA),
    .rdata_bus   (AHB_HRDATA),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
    if (!AHB_HRESETn) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    data_done = 1'b0;
    data_err  = 1'b0;
    data_tmo  = 1'b0;
    unique case (state)
      ST_IDLE: if (cmd_valid) state_nxt = cmd_ok ? ST_ADDR : ST_RESP;
      ST_ADDR: if (AHB_HREADY) state_nxt = ST_DATA;
      ST_DATA: begin
        // ERROR's first cycle has HREADY low, so it just counts as a wait state.
        if (AHB_HREADY) begin
          state_nxt = ST_RESP;
          data_done = 1'b1;
          data_err  = (AHB_HRESP != HRESP_OKAY);
        end else if (timeout_hit) begin
          state_nxt = ST_RESP;
          data_tmo  = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
    if (!AHB_HRESETn) begin
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_size    <= '0;
      lat_wdata   <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= cmd_write;
        lat_addr  <= cmd_addr;
        lat_size  <= cmd_size;
        lat_wdata <= cmd_wdata;
        wait_cnt  <= '0;
        if (!cmd_ok) begin
          rsp_rdata   <= '0;
          rsp_error   <= 1'b1;
          rsp_timeout <= 1'b0;
        end
      end
      if ((state == ST_DATA) && !AHB_HREADY && (TIMEOUT_CYCLES != 0)) wait_cnt <= wait_nxt;
      if (data_done) begin
        rsp_rdata   <= (data_err || lat_write) ? '0 : rdata_ext;
        rsp_error   <= data_err;
        rsp_timeout <= 1'b0;
      end
      if (data_tmo) begin
        rsp_rdata   <= '0;
        rsp_error   <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

  assign cmd_ready     = (state == ST_IDLE);
  assign rsp_valid     = (state == ST_RESP);
  assign AHB_HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign AHB_HADDR     = lat_addr;
  assign AHB_HWRITE    = lat_write;
  assign AHB_HSIZE     = lat_size;
  assign AHB_HBURST    = HBURST_SINGLE;
  assign AHB_HPROT     = HPROT_VAL;
  assign AHB_HMASTLOCK = 1'b0;

endmodule
